imem_loader: RTL

Program loader that writes the instruction memory which the fetch path (PC counter, instruction memory, decoder, control unit) reads. It accepts a little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. Each word goes out on an IMEM write port at consecutive word-aligned byte addresses with an even-parity bit for the fault-tolerant memory. The CPU is held in reset (`cpu_hold`) until a complete, well-formed image has been written.

---
 rtl/imem_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to IMEM with even parity, and holds the CPU until the image is complete.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [7:0]      s_data,
   input  logic            s_last,
   output logic            imem_we,
   output logic [31:0]     imem_waddr,
   output logic [31:0]     imem_wdata,
   output logic            imem_wpar,
   output logic [ADDR_W:0] word_count,
   output logic            load_done,
   output logic            load_error,
   output logic            cpu_hold
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [1:0]      byte_idx_q;
   logic            last_q;
   logic [ADDR_W:0] word_count_q;
   logic [7:0]      lane_q [3];
   logic            s_ready_q, imem_we_q, load_done_q, load_error_q, cpu_hold_q;
   logic [31:0]     waddr_q, wdata_q;
   logic            wpar_q;

   logic            hs, start_ok, overflow;
   logic [31:0]     word_full;

   assign hs        = s_valid && s_ready_q;
   assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
   assign overflow  = (word_count_q == CAPACITY);
   // The fourth byte goes straight into the write register, so only lanes 0..2 are buffered.
   assign word_full = {s_data, lane_q[2], lane_q[1], lane_q[0]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) state_d = ST_RECV;
         end
         ST_RECV: begin
            if (hs) begin
               if (overflow)                state_d = ST_ERROR;
               else if (byte_idx_q == 2'd3) state_d = ST_WRITE;
               else if (s_last)             state_d = ST_ERROR;
            end
         end
         ST_WRITE: state_d = last_q ? ST_DONE : ST_RECV;
         default:  state_d = ST_IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         always_ff @(posedge clk) begin
            if (rst) begin
               lane_q[gi] <= '0;
            end else if (hs && !overflow && byte_idx_q == 2'(gi)) begin
               lane_q[gi] <= s_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         byte_idx_q   <= '0;
         last_q       <= 1'b0;
         word_count_q <= '0;
         s_ready_q    <= 1'b0;
         imem_we_q    <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         wpar_q       <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         cpu_hold_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         // Outputs are registered from the next state so they line up with state_q.
         s_ready_q    <= (state_d == ST_RECV);
         imem_we_q    <= (state_d == ST_WRITE);
         load_done_q  <= (state_d == ST_DONE);
         load_error_q <= (state_d == ST_ERROR);
         cpu_hold_q   <= (state_d != ST_DONE);

         if (start_ok) begin
            word_count_q <= '0;
            byte_idx_q   <= '0;
            last_q       <= 1'b0;
         end

         if (hs && !overflow) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
               last_q  <= s_last;
               waddr_q <= 32'(word_count_q) << 2;
               wdata_q <= word_full;
               wpar_q  <= ^word_full;
            end
         end

         if (state_q == ST_WRITE) word_count_q <= word_count_q + ONE;
      end
   end

   assign s_ready    = s_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;
   assign imem_wpar  = wpar_q;
   assign word_count = word_count_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;
   assign cpu_hold   = cpu_hold_q;

endmodule
